mmio_periph_resp: RTL and testbench

//  Peripheral-side responder of the CPU data bus (Bus_addr/Bus_we/Bus_wdata -> Bus_rdata).

---
 rtl/mmio_periph_resp_pkg.sv | 38 +++
 rtl/mmio_periph_resp_seg7_decode.sv | 32 +++
 rtl/mmio_periph_resp.sv | 155 +++++++++++++++
 tb/tb_mmio_periph_resp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_periph_resp_pkg.sv
// Shared constants, register-select type and address decode for the MMIO peripheral responder.
package mmio_periph_resp_pkg;

    localparam logic [19:0] MMIO_PAGE = 20'hFFFFF;

    localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DIG,
        SEL_TCNT,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN
    } reg_sel_e;

    // Word-granular decode; the byte offset within a word never selects a register.
    function automatic reg_sel_e decode_sel(input logic [29:0] word_addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word_addr == ADDR_DIG[31:2])  sel = SEL_DIG;
        if (word_addr == ADDR_TCNT[31:2]) sel = SEL_TCNT;
        if (word_addr == ADDR_TDIV[31:2]) sel = SEL_TDIV;
        if (word_addr == ADDR_LED[31:2])  sel = SEL_LED;
        if (word_addr == ADDR_SW[31:2])   sel = SEL_SW;
        if (word_addr == ADDR_BTN[31:2])  sel = SEL_BTN;
        return sel;
    endfunction

endpackage

// File: rtl/mmio_periph_resp_seg7_decode.sv
// Hex nibble to active-low 7-segment pattern {dp,g,f,e,d,c,b,a}; decimal point always off.
module seg7_decode
    import mmio_periph_resp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mmio_periph_resp.sv
// MMIO peripheral responder on the 0xFFFFF000 page: LED, switches, buttons, 7-seg scanner, timer.
// The timer (TCNT/TDIV/prescaler) is built only when MMIO_TIMER_EN is defined.
module mmio_periph_resp
    import mmio_periph_resp_pkg::*;
#(
    parameter int SCAN_DIV  = 20000,
    parameter int TIMER_DIV = 100
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic [3:0]  Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic        periph_hit,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  DN_seg
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  we);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    reg_sel_e    sel;
    logic        wr_en;
    logic [31:0] tcnt_rd, tdiv_rd;
    logic [31:0] led_wr;

    logic [23:0]       led_q, led_d;
    logic [31:0]       dig_q, dig_d;
    logic [23:0]       sw_meta_q, sw_sync_q;
    logic [4:0]        btn_meta_q, btn_sync_q;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        scan_idx_q, scan_idx_d;

    logic unused_bits;
    assign unused_bits = ^{Bus_addr[1:0], led_wr[31:24]};

    assign periph_hit = (Bus_addr[31:12] == MMIO_PAGE);
    assign sel        = decode_sel(Bus_addr[31:2]);
    assign wr_en      = periph_hit && (|Bus_we);

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        led_wr     = lane_merge({8'h00, led_q}, Bus_wdata, Bus_we);
        led_d      = led_q;
        dig_d      = dig_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (wr_en && sel == SEL_LED) led_d = led_wr[23:0];
        if (wr_en && sel == SEL_DIG) dig_d = lane_merge(dig_q, Bus_wdata, Bus_we);
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led_q      <= '0;
            dig_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            led_q      <= led_d;
            dig_q      <= dig_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d, presc_q, presc_d;
    logic [31:0] presc_top, tcnt_inc;
    logic        tick;

    // A TCNT write landing on a tick merges over the incremented count, not the old one.
    always_comb begin
        presc_top = (tdiv_q == 32'd0) ? 32'd0 : tdiv_q - 32'd1;
        tick      = (presc_q >= presc_top);
        tcnt_inc  = tcnt_q + {31'd0, tick};
        tcnt_d    = tcnt_inc;
        tdiv_d    = tdiv_q;
        presc_d   = tick ? 32'd0 : presc_q + 32'd1;
        if (wr_en && sel == SEL_TCNT) tcnt_d = lane_merge(tcnt_inc, Bus_wdata, Bus_we);
        if (wr_en && sel == SEL_TDIV) begin
            tdiv_d  = lane_merge(tdiv_q, Bus_wdata, Bus_we);
            presc_d = 32'd0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            tcnt_q  <= '0;
            tdiv_q  <= 32'(TIMER_DIV);
            presc_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            tdiv_q  <= tdiv_d;
            presc_q <= presc_d;
        end
    end

    assign tcnt_rd = tcnt_q;
    assign tdiv_rd = tdiv_q;
`else
    localparam logic [31:0] TIMER_DIV_UNUSED = 32'(TIMER_DIV);
    assign tcnt_rd = '0;
    assign tdiv_rd = '0;
`endif

    always_comb begin
        Bus_rdata = '0;
        if (periph_hit) begin
            case (sel)
                SEL_DIG:  Bus_rdata = dig_q;
                SEL_TCNT: Bus_rdata = tcnt_rd;
                SEL_TDIV: Bus_rdata = tdiv_rd;
                SEL_LED:  Bus_rdata = {8'h00, led_q};
                SEL_SW:   Bus_rdata = {8'h00, sw_sync_q};
                SEL_BTN:  Bus_rdata = {27'd0, btn_sync_q};
                default:  Bus_rdata = '0;
            endcase
        end
    end

    assign led    = led_q;
    assign dig_en = ~(8'd1 << scan_idx_q);

    seg7_decode u_seg7_decode (
        .nibble_i (dig_q[{scan_idx_q, 2'b00} +: 4]),
        .seg_o    (DN_seg)
    );

endmodule

// File: tb/tb_mmio_periph_resp.sv
// Directed self-checking bench for mmio_periph_resp (SCAN_DIV=4, TIMER_DIV=3); timer checks follow MMIO_TIMER_EN.
module tb_mmio_periph_resp;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic [3:0]  Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic        periph_hit;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  DN_seg;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_periph_resp #(
        .SCAN_DIV  (4),
        .TIMER_DIV (3)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .periph_hit (periph_hit),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .DN_seg     (DN_seg)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each step passes exactly one rising edge and leaves us in the low phase.
    task automatic step(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        Bus_addr  = addr;
        Bus_we    = we;
        Bus_wdata = data;
        @(negedge cpu_clk);
        Bus_we    = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        Bus_addr = addr;
        Bus_we   = 4'h0;
        #1;
        data = Bus_rdata;
    endtask

    logic [31:0] rd;

    initial begin
        cpu_rst   = 1'b1;
        Bus_addr  = 32'h0;
        Bus_we    = 4'h0;
        Bus_wdata = 32'h0;
        sw        = 24'h0;
        button    = 5'h0;
        step(2);
        cpu_rst = 1'b0;
        #1;
        check("rst_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        check("rst_seg",    {24'h0, DN_seg}, 32'h0000_00C0);
        check("rst_led",    {8'h0, led},     32'h0);

        // LED partial-lane write
        bus_write(32'hFFFF_F060, 4'b0011, 32'h00AB_CDEF);
        #1;
        check("led_lanes", {8'h0, led}, 32'h0000_CDEF);
        bus_read(32'hFFFF_F060, rd);
        check("led_read", rd, 32'h0000_CDEF);

        // Asynchronous reset in the middle of a scan slot
        bus_write(32'hFFFF_F000, 4'hF, 32'h1234_5678);
        step(4);
        #2 cpu_rst = 1'b1;
        #1;
        check("arst_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        check("arst_seg",    {24'h0, DN_seg}, 32'h0000_00C0);
        check("arst_led",    {8'h0, led},     32'h0);
        bus_read(32'hFFFF_F000, rd);
        check("arst_dig", rd, 32'h0);
`ifdef MMIO_TIMER_EN
        bus_read(32'hFFFF_F024, rd);
        check("arst_tdiv", rd, 32'h0000_0003);
`endif
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Scanner: DIG write lands at edge 1 after reset release
        bus_write(32'hFFFF_F000, 4'hF, 32'h89AB_CDEF);
        #1;
        check("scan0_en",  {24'h0, dig_en}, 32'h0000_00FE);
        check("scan0_seg", {24'h0, DN_seg}, 32'h0000_008E);
        step(2);
        check("scan3_en", {24'h0, dig_en}, 32'h0000_00FE);
        step(1);
        check("scan4_en",  {24'h0, dig_en}, 32'h0000_00FD);
        check("scan4_seg", {24'h0, DN_seg}, 32'h0000_0086);
        step(27);
        check("scan31_en",  {24'h0, dig_en}, 32'h0000_007F);
        check("scan31_seg", {24'h0, DN_seg}, 32'h0000_0080);
        step(1);
        check("scan32_en",  {24'h0, dig_en}, 32'h0000_00FE);
        check("scan32_seg", {24'h0, DN_seg}, 32'h0000_008E);

        // Switch / button synchroniser latency
        sw = 24'h12_3456;
        step(1);
        bus_read(32'hFFFF_F070, rd);
        check("sw_edge1", rd, 32'h0);
        step(1);
        bus_read(32'hFFFF_F070, rd);
        check("sw_edge2", rd, 32'h0012_3456);
        sw = 24'h65_4321;
        step(1);
        bus_read(32'hFFFF_F070, rd);
        check("sw_chg1", rd, 32'h0012_3456);
        step(1);
        bus_read(32'hFFFF_F070, rd);
        check("sw_chg2", rd, 32'h0065_4321);
        button = 5'h15;
        step(2);
        bus_read(32'hFFFF_F078, rd);
        check("btn", rd, 32'h0000_0015);

        // Unmapped in-page, off-page and read-only addresses
        bus_read(32'hFFFF_F010, rd);
        check("unmapped_rd",  rd, 32'h0);
        check("unmapped_hit", {31'h0, periph_hit}, 32'h1);
        bus_write(32'hFFFF_F060, 4'b0100, 32'h0077_0000);
        Bus_addr  = 32'h0000_1000;
        Bus_we    = 4'hF;
        Bus_wdata = 32'hFFFF_FFFF;
        #1;
        check("offpage_hit", {31'h0, periph_hit}, 32'h0);
        check("offpage_rd",  Bus_rdata, 32'h0);
        @(negedge cpu_clk);
        Bus_we = 4'h0;
        check("offpage_led", {8'h0, led}, 32'h0077_0000);
        bus_read(32'hFFFF_F000, rd);
        check("offpage_dig", rd, 32'h89AB_CDEF);
        bus_write(32'hFFFF_F070, 4'hF, 32'h0);
        bus_read(32'hFFFF_F070, rd);
        check("ro_sw", rd, 32'h0065_4321);

`ifdef MMIO_TIMER_EN
        // Timer, TIMER_DIV=3: TDIV write at edge A clears the prescaler
        bus_write(32'hFFFF_F024, 4'hF, 32'h0000_0003);
        bus_write(32'hFFFF_F020, 4'hF, 32'h0000_0000);
        step(7);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_a8", rd, 32'h0000_0002);
        step(1);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_a9", rd, 32'h0000_0003);
        bus_write(32'hFFFF_F020, 4'hF, 32'hFFFF_FFFF);
        step(1);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_a11", rd, 32'hFFFF_FFFF);
        step(1);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_wrap", rd, 32'h0);
        step(2);
        bus_write(32'hFFFF_F020, 4'hF, 32'h0000_02FF);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_wr_tick", rd, 32'h0000_02FF);
        step(2);
        bus_write(32'hFFFF_F020, 4'b0001, 32'h1111_1111);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_lane_tick", rd, 32'h0000_0311);
        bus_read(32'hFFFF_F024, rd);
        check("tdiv_rd", rd, 32'h0000_0003);
`else
        bus_write(32'hFFFF_F020, 4'hF, 32'h1234_5678);
        bus_read(32'hFFFF_F020, rd);
        check("tcnt_absent", rd, 32'h0);
        bus_read(32'hFFFF_F024, rd);
        check("tdiv_absent", rd, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
